// File: rtl/ifft_pkg.sv
// Shared definitions for the 8-point iterative inverse FFT.
//   - Q16.16 twiddle constants (conjugated forward twiddles)
//   - FSM state encoding
//   - 12-entry butterfly schedule: operand indices and twiddle per step
//   - 3-bit bit-reverse table used when a frame is loaded
package ifft_pkg;

    localparam int IFFT_POINTS = 8;
    localparam int IFFT_WIDTH  = 32;
    localparam int IFFT_STEPS  = 12;

    localparam logic signed [IFFT_WIDTH-1:0] ONE    = 32'sh0001_0000;
    localparam logic signed [IFFT_WIDTH-1:0] ZERO   = 32'sh0000_0000;
    localparam logic signed [IFFT_WIDTH-1:0] P_0707 = 32'sh0000_B505;
    localparam logic signed [IFFT_WIDTH-1:0] N_0707 = 32'shFFFF_4AFB;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef logic [2:0] idx_t;
    typedef logic [3:0] cnt_t;

    typedef struct packed {
        idx_t                          idx0;
        idx_t                          idx1;
        logic signed [IFFT_WIDTH-1:0]  w_re;
        logic signed [IFFT_WIDTH-1:0]  w_im;
    } sched_t;

    // Butterfly schedule. Butterflies inside one stage touch disjoint pairs,
    // so the order within a stage does not matter.
    function automatic sched_t sched_lookup(input cnt_t cnt);
        sched_t s;
        case (cnt)
            4'd0:    s = '{idx0: 3'd0, idx1: 3'd1, w_re: ONE,    w_im: ZERO};
            4'd1:    s = '{idx0: 3'd2, idx1: 3'd3, w_re: ONE,    w_im: ZERO};
            4'd2:    s = '{idx0: 3'd4, idx1: 3'd5, w_re: ONE,    w_im: ZERO};
            4'd3:    s = '{idx0: 3'd6, idx1: 3'd7, w_re: ONE,    w_im: ZERO};
            4'd4:    s = '{idx0: 3'd0, idx1: 3'd2, w_re: ONE,    w_im: ZERO};
            4'd5:    s = '{idx0: 3'd1, idx1: 3'd3, w_re: ZERO,   w_im: ONE};
            4'd6:    s = '{idx0: 3'd4, idx1: 3'd6, w_re: ONE,    w_im: ZERO};
            4'd7:    s = '{idx0: 3'd5, idx1: 3'd7, w_re: ZERO,   w_im: ONE};
            4'd8:    s = '{idx0: 3'd0, idx1: 3'd4, w_re: ONE,    w_im: ZERO};
            4'd9:    s = '{idx0: 3'd1, idx1: 3'd5, w_re: P_0707, w_im: P_0707};
            4'd10:   s = '{idx0: 3'd2, idx1: 3'd6, w_re: ZERO,   w_im: ONE};
            4'd11:   s = '{idx0: 3'd3, idx1: 3'd7, w_re: N_0707, w_im: P_0707};
            default: s = '{idx0: 3'd0, idx1: 3'd0, w_re: ONE,    w_im: ZERO};
        endcase
        return s;
    endfunction

    function automatic idx_t bitrev(input idx_t i);
        idx_t r;
        case (i)
            3'd0:    r = 3'd0;
            3'd1:    r = 3'd4;
            3'd2:    r = 3'd2;
            3'd3:    r = 3'd6;
            3'd4:    r = 3'd1;
            3'd5:    r = 3'd5;
            3'd6:    r = 3'd3;
            default: r = 3'd7;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ifft_8points_iterative_butterfly.sv
// ifft_butterfly: combinational radix-2 DIT butterfly in Q16.16.
//   t  = x1 * W   (64-bit products, keep bits [47:16] of each sum)
//   y0 = (x0 + t) >>> i_shift,  y1 = (x0 - t) >>> i_shift  (32-bit wrap)
// Ports: i_x0_*, i_x1_* operands; i_w_* twiddle; i_shift right-shift
// amount applied to both results; o_y0_*, o_y1_* results.
module ifft_butterfly
    import ifft_pkg::*;
(
    input  logic signed [IFFT_WIDTH-1:0] i_x0_re,
    input  logic signed [IFFT_WIDTH-1:0] i_x0_im,
    input  logic signed [IFFT_WIDTH-1:0] i_x1_re,
    input  logic signed [IFFT_WIDTH-1:0] i_x1_im,
    input  logic signed [IFFT_WIDTH-1:0] i_w_re,
    input  logic signed [IFFT_WIDTH-1:0] i_w_im,
    input  logic        [1:0]            i_shift,
    output logic signed [IFFT_WIDTH-1:0] o_y0_re,
    output logic signed [IFFT_WIDTH-1:0] o_y0_im,
    output logic signed [IFFT_WIDTH-1:0] o_y1_re,
    output logic signed [IFFT_WIDTH-1:0] o_y1_im
);

    localparam int PW = 2 * IFFT_WIDTH;

    logic signed [PW-1:0]         p_rr, p_ii, p_ri, p_ir;
    logic signed [IFFT_WIDTH-1:0] t_re, t_im;
    logic signed [IFFT_WIDTH-1:0] s0_re, s0_im, s1_re, s1_im;

    always_comb begin
        p_rr  = PW'(i_x1_re) * PW'(i_w_re);
        p_ii  = PW'(i_x1_im) * PW'(i_w_im);
        p_ri  = PW'(i_x1_re) * PW'(i_w_im);
        p_ir  = PW'(i_x1_im) * PW'(i_w_re);
        // Drop the 16 fraction bits of the Q32.32 product (truncation).
        t_re  = IFFT_WIDTH'((p_rr - p_ii) >>> 16);
        t_im  = IFFT_WIDTH'((p_ri + p_ir) >>> 16);
        s0_re = i_x0_re + t_re;
        s0_im = i_x0_im + t_im;
        s1_re = i_x0_re - t_re;
        s1_im = i_x0_im - t_im;
        o_y0_re = s0_re >>> i_shift;
        o_y0_im = s0_im >>> i_shift;
        o_y1_re = s1_re >>> i_shift;
        o_y1_im = s1_im >>> i_shift;
    end

endmodule

// File: rtl/ifft_8points_iterative.sv
// ifft_8points_iterative: 8-point inverse FFT (Q16.16, scaled by 1/8) using a
// single time-multiplexed butterfly over 12 steps.
// Ports:
//   i_clk, i_rst_n         clock, async active-low reset
//   i_valid / o_ready      input frame handshake (o_ready = state IDLE)
//   i_data_re / i_data_im  X[k], natural order
//   o_valid / i_ready      output frame handshake (o_valid = state DONE)
//   o_data_re / o_data_im  x[n], natural order, registered
// Build option: define IFFT_STAGE_SCALE_EN to halve every butterfly result
// (1/2 per stage); otherwise only stage 3 is shifted, by 3.
module ifft_8points_iterative
    import ifft_pkg::*;
#(
    parameter int NUM_POINTS = IFFT_POINTS,
    parameter int WIDTH      = IFFT_WIDTH
) (
    input  logic                                 i_clk,
    input  logic                                 i_rst_n,
    input  logic                                 i_valid,
    output logic                                 o_ready,
    input  logic signed [NUM_POINTS-1:0][WIDTH-1:0] i_data_re,
    input  logic signed [NUM_POINTS-1:0][WIDTH-1:0] i_data_im,
    output logic                                 o_valid,
    input  logic                                 i_ready,
    output logic signed [NUM_POINTS-1:0][WIDTH-1:0] o_data_re,
    output logic signed [NUM_POINTS-1:0][WIDTH-1:0] o_data_im
);

    state_e state_q, state_d;
    cnt_t   cnt_q, cnt_d;

    logic [NUM_POINTS-1:0][WIDTH-1:0] work_re_q, work_re_d;
    logic [NUM_POINTS-1:0][WIDTH-1:0] work_im_q, work_im_d;
    logic [NUM_POINTS-1:0][WIDTH-1:0] out_re_q, out_re_d;
    logic [NUM_POINTS-1:0][WIDTH-1:0] out_im_q, out_im_d;

    sched_t                  sched;
    logic [1:0]              shift;
    logic signed [WIDTH-1:0] y0_re, y0_im, y1_re, y1_im;

    assign sched = sched_lookup(cnt_q);

`ifdef IFFT_STAGE_SCALE_EN
    assign shift = 2'd1;
`else
    assign shift = (cnt_q >= 4'd8) ? 2'd3 : 2'd0;
`endif

    ifft_butterfly u_bfly (
        .i_x0_re (work_re_q[sched.idx0]),
        .i_x0_im (work_im_q[sched.idx0]),
        .i_x1_re (work_re_q[sched.idx1]),
        .i_x1_im (work_im_q[sched.idx1]),
        .i_w_re  (sched.w_re),
        .i_w_im  (sched.w_im),
        .i_shift (shift),
        .o_y0_re (y0_re),
        .o_y0_im (y0_im),
        .o_y1_re (y1_re),
        .o_y1_im (y1_im)
    );

    assign o_ready   = (state_q == IDLE);
    assign o_valid   = (state_q == DONE);
    assign o_data_re = out_re_q;
    assign o_data_im = out_im_q;

    always_comb begin
        // NOTE: every _d gets a hold value first so no path leaves it unassigned (no latch).
        state_d   = state_q;
        cnt_d     = cnt_q;
        work_re_d = work_re_q;
        work_im_d = work_im_q;
        out_re_d  = out_re_q;
        out_im_d  = out_im_q;
        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    for (int i = 0; i < NUM_POINTS; i++) begin
                        work_re_d[i] = i_data_re[bitrev(idx_t'(i))];
                        work_im_d[i] = i_data_im[bitrev(idx_t'(i))];
                    end
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                work_re_d[sched.idx0] = y0_re;
                work_im_d[sched.idx0] = y0_im;
                work_re_d[sched.idx1] = y1_re;
                work_im_d[sched.idx1] = y1_im;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == cnt_t'(IFFT_STEPS - 1)) begin
                    // Publish the frame including the last butterfly's results.
                    out_re_d = work_re_d;
                    out_im_d = work_im_d;
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (i_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            // NOTE: the work array is reset too, so an aborted frame leaves no stale data behind.
            work_re_q <= '0;
            work_im_q <= '0;
            out_re_q  <= '0;
            out_im_q  <= '0;
        end else begin
            // NOTE: non-blocking updates so every flop samples the pre-edge values.
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            work_re_q <= work_re_d;
            work_im_q <= work_im_d;
            out_re_q  <= out_re_d;
            out_im_q  <= out_im_d;
        end
    end

endmodule

// File: doc/ifft_8points_iterative.md
# ifft_8points_iterative

Inverse 8-point radix-2 DIT transform in Q16.16 fixed point, scaled by 1/8. It is the synthesis-side counterpart of the team's 8-point pipelined forward FFT, so a forward FFT followed by this block returns the original samples. It is an area-reduced design: one shared butterfly is time-multiplexed over the 12 butterflies of the transform under a small FSM. Frames move in and out over valid/ready handshakes.

## Interface
- `NUM_POINTS`, 8: transform size. Fixed; any other value is unsupported.
- `WIDTH`, 32: sample width in Q16.16 two's complement.
- `i_clk`  in  1: clock.
- `i_rst_n`  in  1: reset, asynchronous, active-low.
- `i_valid`  in  1: input frame valid.
- `o_ready`  out  1: block can accept a frame; combinational decode of state == IDLE.
- `i_data_re`, `i_data_im`  in  [NUM_POINTS-1:0][WIDTH-1:0] signed: frequency-domain input X[k], natural order.
- `o_valid`  out  1: output frame valid.
- `i_ready`  in  1: downstream accepts the output frame.
- `o_data_re`, `o_data_im`  out  [NUM_POINTS-1:0][WIDTH-1:0] signed: time-domain output x[n], natural order, registered.

## Operation
- FSM has three states: IDLE, RUN, DONE.
- **IDLE:** `o_ready`=1.
  - On `i_valid`&&`o_ready`: load work registers in bit-reversed order, work[i] = X[bitrev(i)], with source order 0,4,2,6,1,5,3,7.
  - Then clear step counter cnt (4 bit) and go to RUN.
- **RUN:** each cycle apply one butterfly to the work registers in place, then cnt++.
  - After cnt==11 is applied, go to DONE.
- **Schedule, stage 1 (cnt 0–3):** pairs (0,1) (2,3) (4,5) (6,7); twiddle W=1.
- **Schedule, stage 2 (cnt 4–7):** pairs (0,2) (1,3) (4,6) (5,7).
  - Twiddle is 1 for pair positions 0 and 4.
  - Twiddle is +j = (0, ONE) for positions 1 and 5.
- **Schedule, stage 3 (cnt 8–11):** pairs (k, k+4) for k=0..3 with these twiddles:
  - k=0: (ONE, 0)
  - k=1: (P_0707, P_0707)
  - k=2: (0, ONE)
  - k=3: (N_0707, P_0707)
  - These are the conjugated forward twiddles.
- **Butterfly:** t = x1·W; y0 = x0 + t; y1 = x0 − t.
  - Each real product is 64-bit signed. Each of t.re and t.im is the 64-bit sum/difference of its two products, keeping bits [47:16] (truncation).
  - The additions wrap at WIDTH bits. There is no saturation.
- **DONE:** `o_valid`=1.
  - `o_data` holds the work registers, which were copied to the output registers on the final RUN edge.
  - On `i_valid`... no: on `o_valid`&&`i_ready`, go to IDLE.
- A frame is not accepted in the same cycle its output handshake completes.
- **Reset values:** state IDLE, so `o_ready`=1 while in reset. `o_valid`=0, `o_data_*`=0, work registers=0, cnt=0.
- **Reset mid-RUN or mid-DONE:** the frame is discarded and all outputs return to their reset values immediately.
- `i_valid` while not in IDLE is ignored. The input data is not sampled.

## Timing
- Accept edge T0. Butterfly edges T1..T12. `o_valid` rises after T12, i.e. 12 cycles of latency from accept.
- `o_data`/`o_valid` stay stable while `i_ready`=0.
- Minimum frame period is 14 cycles: T13 is the output handshake, T14 is the earliest next accept.

## Configuration
- **`IFFT_STAGE_SCALE_EN` defined:** every butterfly result (y0, y1) is arithmetic-shifted right by 1 before write-back. Total scaling is 1/8. Intermediate values cannot overflow for |input| < 2^14.
- **Undefined:** stages 1–2 are unscaled, and stage-3 results are arithmetic-shifted right by 3 before write-back. Total scaling is 1/8, with better precision and smaller headroom.
- Both modes must meet the same test-plan tolerances.

## Structure
- Package `ifft_pkg` holds:
  - Twiddle constants: ONE=0x00010000, ZERO, P_0707=0x0000B505, N_0707=0xFFFF4AFB.
  - State enum.
  - 12-entry schedule lookup table: idx0, idx1, twiddle re/im per cnt.
  - Bit-reverse table.
- Sub-module `ifft_butterfly`: purely combinational, single instance. It takes x0, x1, W and a shift amount, and returns y0, y1.

## Test plan
- **Impulse:** X[0]=0x00010000, others 0 → every x[n]=(0x00002000, 0); `o_valid` exactly 12 cycles after accept.
- **DC:** all X[k].re=0x00010000 → x[0]=(0x00010000, 0); x[1..7]=0 within ±2 LSB.
- **Single tone:** X[1].re=0x00080000 → x[n]=e^{+j2πn/8}, within ±4 LSB:
  - x[0]=(0x10000, 0)
  - x[1]≈(0xB505, 0xB505)
  - x[2]=(0, 0x10000)
  - x[4]=(0xFFFF0000, 0)
- **Backpressure:** hold `i_ready`=0 for 5 cycles after `o_valid`.
  - `o_data`/`o_valid` stable, `o_ready`=0, and an offered frame is not accepted.
  - After the handshake, `o_ready`=1 the next cycle.
- **Reset mid-RUN:** assert `i_rst_n`=0 at butterfly step 6.
  - `o_valid`=0, `o_data`=0, `o_ready`=1 immediately.
  - The next frame, an impulse, yields all 0x2000.
- **Round trip:** feed the forward-FFT output of x=[1,2,3,4,0,−1,−2,−3]·2^16 → recovers x within ±8 LSB in both `IFFT_STAGE_SCALE_EN` builds.
